// File: rtl/cpu_phase_sequencer_if.sv
// Datapath-facing bundle of the CPU phase sequencer.
// The sequencer (master) drives the phase enables, the write/flag gates and
// the ROM address. The decoder/flag register (slave) return the opcode,
// the condition field and the current NZVC flags.
interface cpu_phase_sequencer_if #(
    parameter int PC_W = 4
);
    logic [3:0]      op_code;
    logic [1:0]      condition;
    logic [3:0]      nzvc;
    logic            fetch_clk;
    logic            dec_clk;
    logic            alu_clk;
    logic            wb_en;
    logic            flag_we;
    logic [PC_W-1:0] pc;

    modport master (
        input  op_code, condition, nzvc,
        output fetch_clk, dec_clk, alu_clk, wb_en, flag_we, pc
    );

    modport slave (
        output op_code, condition, nzvc,
        input  fetch_clk, dec_clk, alu_clk, wb_en, flag_we, pc
    );
endinterface

// File: rtl/cpu_phase_sequencer.sv
// Central control FSM of the CPU datapath: walks every instruction through
// FETCH -> DECODE -> EXECUTE, owns the program counter, evaluates the
// condition field against NZVC and gates write-back / flag update.
// Optional build macro CPU_SINGLE_STEP_EN adds a 'step' input and a PAUSE
// state entered after every instruction; a rising edge on 'step' releases
// exactly one further instruction.
module cpu_phase_sequencer #(
    parameter int PC_W     = 4,
    parameter int PROG_END = 15,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             halt_req,
`ifdef CPU_SINGLE_STEP_EN
    input  logic             step,
`endif
    cpu_phase_sequencer_if.master bus,
    output logic             halted,
    output logic             illegal_op,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FETCH   = 3'd1;
    localparam logic [2:0] S_DECODE  = 3'd2;
    localparam logic [2:0] S_EXECUTE = 3'd3;
    localparam logic [2:0] S_HALTED  = 3'd4;
`ifdef CPU_SINGLE_STEP_EN
    localparam logic [2:0] S_PAUSE   = 3'd5;
`endif

    localparam logic [PC_W-1:0] LAST_PC   = PC_W'(PROG_END);
    localparam logic [3:0]      OP_CMP    = 4'b1001;
    localparam logic [3:0]      OP_MAX    = 4'b1001;

    logic [2:0]       state;
    logic [PC_W-1:0]  pc_q;
    logic [CNT_W-1:0] count_q;
    logic             illegal_q;
    logic             halt_pending;
    logic             cond_pass;
    logic             op_legal;
    logic             op_is_cmp;
    logic             cond_now;
    logic             stop_now;
    logic             unused_carry;

    // The carry flag takes part in none of the supported conditions.
    assign unused_carry = bus.nzvc[0];

`ifdef CPU_SINGLE_STEP_EN
    logic step_d;
    logic step_rise;

    assign step_rise = step & ~step_d;

    // Delayed copy of step so a held-high step releases only one instruction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            step_d <= 1'b0;
        end else begin
            step_d <= step;
        end
    end
`endif

    // Evaluate the condition field against the live flags {N,Z,V,C}.
    always_comb begin
        cond_now = 1'b0;
        case (bus.condition)
            2'b00:   cond_now = ~bus.nzvc[2] & (bus.nzvc[3] == bus.nzvc[1]);
            2'b01:   cond_now = bus.nzvc[3] ^ bus.nzvc[1];
            2'b10:   cond_now = bus.nzvc[2];
            default: cond_now = 1'b1;
        endcase
    end

    // An instruction boundary ends in HALTED on a pending or live halt request
    // or once the last program address has been executed.
    always_comb begin
        stop_now = halt_pending | halt_req | (pc_q == LAST_PC);
    end

    // Phase sequencing, program counter, retire counter and sticky status.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            pc_q         <= '0;
            count_q      <= '0;
            illegal_q    <= 1'b0;
            halt_pending <= 1'b0;
            cond_pass    <= 1'b0;
            op_legal     <= 1'b0;
            op_is_cmp    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (run) begin
                        state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    state <= S_DECODE;
                    if (halt_req) begin
                        halt_pending <= 1'b1;
                    end
                end
                S_DECODE: begin
                    state     <= S_EXECUTE;
                    cond_pass <= cond_now;
                    op_legal  <= (bus.op_code <= OP_MAX);
                    op_is_cmp <= (bus.op_code == OP_CMP);
                    if (halt_req) begin
                        halt_pending <= 1'b1;
                    end
                end
                S_EXECUTE: begin
                    count_q <= count_q + CNT_W'(1);
                    pc_q    <= pc_q + PC_W'(1);
                    if (!op_legal) begin
                        illegal_q <= 1'b1;
                    end
                    if (stop_now) begin
                        state        <= S_HALTED;
                        halt_pending <= 1'b0;
                    end else if (!run) begin
                        state <= S_IDLE;
                    end else begin
`ifdef CPU_SINGLE_STEP_EN
                        state <= S_PAUSE;
`else
                        state <= S_FETCH;
`endif
                    end
                end
                S_HALTED: begin
                    if (!run) begin
                        state <= S_IDLE;
                    end
                end
`ifdef CPU_SINGLE_STEP_EN
                S_PAUSE: begin
                    if (step_rise) begin
                        state <= S_FETCH;
                    end else if (!run) begin
                        state <= S_IDLE;
                    end
                end
`endif
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Outputs decode from the state and the condition/opcode results latched
    // in DECODE, so a reset drops them in the same cycle.
    assign bus.fetch_clk = (state == S_FETCH);
    assign bus.dec_clk   = (state == S_DECODE);
    assign bus.alu_clk   = (state == S_EXECUTE);
    assign bus.flag_we   = (state == S_EXECUTE) & cond_pass & op_legal;
    assign bus.wb_en     = (state == S_EXECUTE) & cond_pass & op_legal & ~op_is_cmp;
    assign bus.pc        = pc_q;
    assign halted        = (state == S_HALTED);
    assign illegal_op    = illegal_q;
    assign instr_count   = count_q;

endmodule

// File: tb/tb_cpu_phase_sequencer.sv
// Self-checking bench for cpu_phase_sequencer: directed scenarios with
// literal expectations, then randomized run/halt/flag/opcode/reset traffic
// compared every cycle against a phase-counting reference model.
module tb_cpu_phase_sequencer;

    localparam int PC_W     = 4;
    localparam int PROG_END = 3;
    localparam int CNT_W    = 16;

    logic clk      = 1'b0;
    logic rst      = 1'b1;
    logic run      = 1'b0;
    logic halt_req = 1'b0;
`ifdef CPU_SINGLE_STEP_EN
    logic step     = 1'b0;
    logic m_step_prev = 1'b0;
    logic m_paused    = 1'b0;
`endif
    logic             halted;
    logic             illegal_op;
    logic [CNT_W-1:0] instr_count;

    int total = 0;
    int bad   = 0;

    // Reference model: m_phase is 0 when no instruction is in flight,
    // otherwise the 1-based phase number of the current instruction.
    int               m_phase   = 0;
    logic             m_halted  = 1'b0;
    logic             m_pend    = 1'b0;
    logic             m_pass    = 1'b0;
    logic             m_legal   = 1'b0;
    logic             m_cmp     = 1'b0;
    logic             m_illegal = 1'b0;
    logic [PC_W-1:0]  m_pc      = '0;
    logic [CNT_W-1:0] m_cnt     = '0;

    cpu_phase_sequencer_if #(.PC_W(PC_W)) bus_if ();

    cpu_phase_sequencer #(
        .PC_W(PC_W),
        .PROG_END(PROG_END),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .run(run),
        .halt_req(halt_req),
`ifdef CPU_SINGLE_STEP_EN
        .step(step),
`endif
        .bus(bus_if),
        .halted(halted),
        .illegal_op(illegal_op),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    function automatic logic condHolds(input logic [1:0] c, input logic [3:0] f);
        logic n, z, v;
        n = f[3];
        z = f[2];
        v = f[1];
        case (c)
            2'b00:   return !z && (n == v);
            2'b01:   return n != v;
            2'b10:   return z;
            default: return 1'b1;
        endcase
    endfunction

    task automatic checkOne(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    task automatic checkOutput();
        checkOne("fetch_clk",   32'(bus_if.fetch_clk), 32'(m_phase == 1));
        checkOne("dec_clk",     32'(bus_if.dec_clk),   32'(m_phase == 2));
        checkOne("alu_clk",     32'(bus_if.alu_clk),   32'(m_phase == 3));
        checkOne("flag_we",     32'(bus_if.flag_we),   32'(m_phase == 3 && m_pass && m_legal));
        checkOne("wb_en",       32'(bus_if.wb_en),     32'(m_phase == 3 && m_pass && m_legal && !m_cmp));
        checkOne("pc",          32'(bus_if.pc),        32'(m_pc));
        checkOne("instr_count", 32'(instr_count),      32'(m_cnt));
        checkOne("halted",      32'(halted),           32'(m_halted));
        checkOne("illegal_op",  32'(illegal_op),       32'(m_illegal));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus();
        run              = ($urandom_range(0, 9) != 0);
        halt_req         = ($urandom_range(0, 24) == 0);
        bus_if.nzvc      = 4'($urandom);
        bus_if.condition = 2'($urandom);
        if (m_phase < 2) begin
            bus_if.op_code = 4'($urandom);
        end
`ifdef CPU_SINGLE_STEP_EN
        step = ($urandom_range(0, 3) == 0);
`endif
    endtask

    // Reference model: advances one clock at a time from the rules of each phase.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_phase   <= 0;
            m_halted  <= 1'b0;
            m_pend    <= 1'b0;
            m_pass    <= 1'b0;
            m_legal   <= 1'b0;
            m_cmp     <= 1'b0;
            m_illegal <= 1'b0;
            m_pc      <= '0;
            m_cnt     <= '0;
`ifdef CPU_SINGLE_STEP_EN
            m_step_prev <= 1'b0;
            m_paused    <= 1'b0;
`endif
        end else begin
`ifdef CPU_SINGLE_STEP_EN
            m_step_prev <= step;
`endif
            if (m_halted) begin
                if (!run) m_halted <= 1'b0;
            end
`ifdef CPU_SINGLE_STEP_EN
            else if (m_paused) begin
                if (step && !m_step_prev) begin
                    m_paused <= 1'b0;
                    m_phase  <= 1;
                end else if (!run) begin
                    m_paused <= 1'b0;
                end
            end
`endif
            else if (m_phase == 0) begin
                if (run) m_phase <= 1;
            end else if (m_phase == 1) begin
                m_phase <= 2;
                if (halt_req) m_pend <= 1'b1;
            end else if (m_phase == 2) begin
                m_phase <= 3;
                m_pass  <= condHolds(bus_if.condition, bus_if.nzvc);
                m_legal <= (bus_if.op_code < 4'd10);
                m_cmp   <= (bus_if.op_code == 4'd9);
                if (halt_req) m_pend <= 1'b1;
            end else begin
                m_cnt <= m_cnt + 16'd1;
                m_pc  <= m_pc + 4'd1;
                if (!m_legal) m_illegal <= 1'b1;
                if (m_pend || halt_req || (m_pc == 4'(PROG_END))) begin
                    m_halted <= 1'b1;
                    m_pend   <= 1'b0;
                    m_phase  <= 0;
                end else if (!run) begin
                    m_phase <= 0;
                end else begin
`ifdef CPU_SINGLE_STEP_EN
                    m_paused <= 1'b1;
                    m_phase  <= 0;
`else
                    m_phase  <= 1;
`endif
                end
            end
        end
    end

    // Every cycle, compare the DUT against the model away from the active edge.
    always @(negedge clk) begin
        checkOutput();
    end

    task automatic checkEnablesOff(input string name);
        checkOne(name, 32'({bus_if.fetch_clk, bus_if.dec_clk, bus_if.alu_clk,
                            bus_if.wb_en, bus_if.flag_we}), 32'd0);
    endtask

    task automatic runDirected();
        bus_if.op_code   = 4'd0;
        bus_if.condition = 2'b11;
        bus_if.nzvc      = 4'b0000;
        rst = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        checkOne("reset_pc", 32'(bus_if.pc), 32'd0);
        checkOne("reset_count", 32'(instr_count), 32'd0);
        checkOne("reset_halted", 32'(halted), 32'd0);
        checkOne("reset_illegal", 32'(illegal_op), 32'd0);
        checkEnablesOff("reset_enables");
        tick();
        checkOne("idle_no_fetch", 32'(bus_if.fetch_clk), 32'd0);
        run = 1'b1;
        tick();
        checkOne("c1_fetch", 32'(bus_if.fetch_clk), 32'd1);
        tick();
        checkOne("c2_dec", 32'(bus_if.dec_clk), 32'd1);
        tick();
        checkOne("c3_alu", 32'(bus_if.alu_clk), 32'd1);
        checkOne("c3_wb", 32'(bus_if.wb_en), 32'd1);
        checkOne("c3_pc_hold", 32'(bus_if.pc), 32'd0);
        tick();
`ifdef CPU_SINGLE_STEP_EN
        checkOne("model_pause_pin", 32'(m_paused), 32'd1);
        checkOne("pause_pc", 32'(bus_if.pc), 32'd1);
        for (int i = 0; i < 10; i++) begin
            checkEnablesOff("pause_no_enables");
            tick();
        end
        step = 1'b1;
        tick();
        checkOne("step_fetch", 32'(bus_if.fetch_clk), 32'd1);
        tick();
        checkOne("step_dec", 32'(bus_if.dec_clk), 32'd1);
        tick();
        checkOne("step_alu", 32'(bus_if.alu_clk), 32'd1);
        tick();
        checkEnablesOff("step_back_to_pause");
        checkOne("step_pc", 32'(bus_if.pc), 32'd2);
        tick();
        checkOne("step_held_no_fetch", 32'(bus_if.fetch_clk), 32'd0);
        step = 1'b0;
`else
        checkOne("i1_pc", 32'(bus_if.pc), 32'd1);
        checkOne("i1_count", 32'(instr_count), 32'd1);
        checkOne("model_pc_pin", 32'(m_pc), 32'd1);
        bus_if.condition = 2'b10;
        bus_if.nzvc      = 4'b0000;
        tick(); tick();
        checkOne("eq_fail_wb", 32'(bus_if.wb_en), 32'd0);
        checkOne("eq_fail_flag", 32'(bus_if.flag_we), 32'd0);
        tick();
        checkOne("eq_fail_pc", 32'(bus_if.pc), 32'd2);
        bus_if.nzvc = 4'b0100;
        tick(); tick();
        checkOne("eq_pass_wb", 32'(bus_if.wb_en), 32'd1);
        tick();
        bus_if.condition = 2'b00;
        bus_if.nzvc      = 4'b1010;
        tick(); tick();
        checkOne("gt_pass_wb", 32'(bus_if.wb_en), 32'd1);
        tick();
        checkOne("end_halted", 32'(halted), 32'd1);
        checkOne("end_pc", 32'(bus_if.pc), 32'd4);
        checkOne("end_count", 32'(instr_count), 32'd4);
        checkOne("model_halt_pin", 32'(m_halted), 32'd1);
        tick();
        checkOne("halted_hold", 32'(halted), 32'd1);
        run = 1'b0;
        tick();
        checkOne("halt_to_idle", 32'(halted), 32'd0);
        checkOne("idle_pc_kept", 32'(bus_if.pc), 32'd4);
        run = 1'b1;
        bus_if.condition = 2'b01;
        tick();
        checkOne("resume_fetch", 32'(bus_if.fetch_clk), 32'd1);
        checkOne("resume_pc", 32'(bus_if.pc), 32'd4);
        tick(); tick();
        checkOne("lt_fail_wb", 32'(bus_if.wb_en), 32'd0);
        tick();
        bus_if.op_code   = 4'b1001;
        bus_if.condition = 2'b11;
        tick(); tick();
        checkOne("cmp_flag", 32'(bus_if.flag_we), 32'd1);
        checkOne("cmp_wb", 32'(bus_if.wb_en), 32'd0);
        tick();
        bus_if.op_code = 4'b1100;
        tick(); tick();
        checkOne("ill_wb", 32'(bus_if.wb_en), 32'd0);
        checkOne("ill_flag", 32'(bus_if.flag_we), 32'd0);
        tick();
        checkOne("ill_sticky_set", 32'(illegal_op), 32'd1);
        bus_if.op_code = 4'b0000;
        tick(); tick();
        checkOne("post_ill_wb", 32'(bus_if.wb_en), 32'd1);
        tick();
        checkOne("pc8", 32'(bus_if.pc), 32'd8);
        tick();
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        checkOne("halt_instr_wb", 32'(bus_if.wb_en), 32'd1);
        tick();
        checkOne("halt_req_halted", 32'(halted), 32'd1);
        checkOne("halt_req_pc", 32'(bus_if.pc), 32'd9);
        checkOne("ill_sticky_hold", 32'(illegal_op), 32'd1);
        run = 1'b0;
        tick();
        run = 1'b1;
        tick(); tick(); tick();
        checkOne("pre_rst_alu", 32'(bus_if.alu_clk), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        checkEnablesOff("rst_enables_drop");
        checkOne("rst_pc", 32'(bus_if.pc), 32'd0);
        checkOne("rst_count", 32'(instr_count), 32'd0);
`endif
        rst = 1'b0;
        run = 1'b0;
        tick(); tick();
        rst = 1'b1;
    endtask

    initial begin
        $display("[TB] directed phase");
        runDirected();
        $display("[TB] random phase");
        for (int i = 0; i < 3000; i++) begin
            tick();
            if (!rst) begin
                rst = 1'b1;
            end else begin
                applyStimulus();
                if ($urandom_range(0, 299) == 0) begin
                    #2;
                    rst = 1'b0;
                end
            end
        end
        rst = 1'b1;
        run = 1'b0;
        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
